// File: rtl/mesm6_prefetch.sv
// mesm6_prefetch
//   Instruction prefetch queue between the instruction bus and the mesm6 core
//   sequencer. Streams WORD_W-bit words from sequential word addresses into a
//   DEPTH-entry FIFO and presents them to the core one half-word opcode at a
//   time. A redirect (jump/interrupt) flushes the queue and restarts fetching
//   at the new target. A bus cycle still in flight at redirect is allowed to
//   complete, and its data is thrown away.
//
// Ports
//   clk           clock, rising edge
//   reset         asynchronous, active-high
//   redirect      load redirect_pc and flush the queue (highest priority)
//   redirect_pc   target half-word PC; bit 0 = 0 selects the left half
//   advance       core consumed the current opcode
//   opcode        current opcode (left half = word[47:24], right = word[23:0])
//   opcode_pc     half-word PC of opcode
//   opcode_valid  opcode/opcode_pc meaningful
//   ibus_fetch    fetch request, held until ibus_done
//   ibus_addr     fetch word address, stable while ibus_fetch = 1
//   ibus_input    fetched word, valid with ibus_done
//   ibus_done     fetch completes this cycle
module mesm6_prefetch #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 15,
  parameter int WORD_W = 48
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect,
  input  logic [ADDR_W:0]     redirect_pc,
  input  logic                advance,
  output logic [WORD_W/2-1:0] opcode,
  output logic [ADDR_W:0]     opcode_pc,
  output logic                opcode_valid,
  output logic                ibus_fetch,
  output logic [ADDR_W-1:0]   ibus_addr,
  input  logic [WORD_W-1:0]   ibus_input,
  input  logic                ibus_done
);

  localparam int OP_W  = WORD_W / 2;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [PTR_W:0]      count, count_nxt;
  logic [ADDR_W:0]     rd_pc;
  logic [ADDR_W-1:0]   fetch_addr, fetch_addr_nxt, bus_addr;
  logic [WORD_W-1:0]   head;
  logic                take, push, pop;

  // DROP never holds data (the queue was flushed on entry), but the guard
  // keeps the core from seeing anything while a stale bus cycle drains.
  assign opcode_valid = (count != '0) && (state != DROP);
  assign opcode_pc    = rd_pc;
  assign head         = mem[rd_ptr];
  assign opcode       = rd_pc[0] ? head[OP_W-1:0] : head[WORD_W-1:OP_W];
  assign ibus_fetch   = (state != IDLE);
  assign ibus_addr    = bus_addr;

  // A redirect overrides both the core's advance and an arriving word.
  // Only the right half consumes a whole word, so only then is the head popped.
  assign take = advance && opcode_valid && !redirect;
  assign pop  = take && rd_pc[0];
  assign push = (state == FETCH) && ibus_done && !redirect;

  always_comb begin
    count_nxt = count;
    if (redirect) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + (PTR_W + 1)'(1);
        2'b01:   count_nxt = count - (PTR_W + 1)'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Next state and next fetch address. The look-ahead on count_nxt lets a
  // fetch start the cycle right after a pop frees a slot, and stops issuing
  // once the word in flight will fill the last slot, so a full queue is
  // never pushed.
  always_comb begin
    state_nxt      = state;
    fetch_addr_nxt = fetch_addr;
    if (redirect) begin
      fetch_addr_nxt = redirect_pc[ADDR_W:1];
      case (state)
        IDLE:        state_nxt = FETCH;
        FETCH, DROP: state_nxt = ibus_done ? FETCH : DROP;
        default:     state_nxt = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (count_nxt < FULL) state_nxt = FETCH;
        end
        FETCH: begin
          if (ibus_done) begin
            fetch_addr_nxt = fetch_addr + ADDR_W'(1);
            state_nxt      = (count_nxt < FULL) ? FETCH : IDLE;
          end
        end
        DROP: begin
          if (ibus_done) state_nxt = FETCH;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Control registers. While a stale cycle drains (DROP) the bus address
  // must stay on the old word even though fetch_addr already holds the new
  // target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      rd_pc      <= '0;
      fetch_addr <= '0;
      bus_addr   <= '0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      fetch_addr <= fetch_addr_nxt;
      bus_addr   <= (state_nxt == DROP) ? bus_addr : fetch_addr_nxt;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        rd_pc  <= redirect_pc;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (take) rd_pc  <= rd_pc + (ADDR_W + 1)'(1);
      end
    end
  end

  // Queue storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ibus_input;
  end

endmodule

// File: tb/tb_mesm6_prefetch.sv
module tb_mesm6_prefetch;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        advance;
  logic [23:0] opcode;
  logic [15:0] opcode_pc;
  logic        opcode_valid;
  logic        ibus_fetch;
  logic [14:0] ibus_addr;
  logic [47:0] ibus_input;
  logic        ibus_done;

  typedef struct {
    logic [15:0] pc;
    logic [23:0] op;
  } exp_t;

  exp_t        sb[$];
  logic [14:0] fetchLog[$];
  int          total = 0;
  int          bad = 0;
  bit          busOn = 0;
  int          busLat = 0;
  int          waitCnt = 0;

  mesm6_prefetch #(.DEPTH(4), .ADDR_W(15), .WORD_W(48)) dut (
    .clk          (clk),
    .reset        (reset),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .advance      (advance),
    .opcode       (opcode),
    .opcode_pc    (opcode_pc),
    .opcode_valid (opcode_valid),
    .ibus_fetch   (ibus_fetch),
    .ibus_addr    (ibus_addr),
    .ibus_input   (ibus_input),
    .ibus_done    (ibus_done)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something unforeseen stalls the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Memory image: mem[w] = w * 0x10001
  function automatic logic [47:0] memWord(input logic [14:0] w);
    return 48'(w) * 48'h10001;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExp(input logic [15:0] pc);
    exp_t        e;
    logic [47:0] mw;
    mw   = memWord(pc[15:1]);
    e.pc = pc;
    e.op = pc[0] ? mw[23:0] : mw[47:24];
    sb.push_back(e);
  endtask

  // Bus responder: answers a pending fetch after busLat wait cycles
  task automatic busDrive();
    if (busOn) begin
      if (ibus_fetch) begin
        if (waitCnt >= busLat) begin
          ibus_done  = 1'b1;
          ibus_input = memWord(ibus_addr);
          fetchLog.push_back(ibus_addr);
          waitCnt    = 0;
        end else begin
          ibus_done = 1'b0;
          waitCnt++;
        end
      end else begin
        ibus_done = 1'b0;
        waitCnt   = 0;
      end
    end
  endtask

  task automatic tick();
    busDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic redir, input logic [15:0] pc,
                               input logic adv);
    redirect    = redir;
    redirect_pc = pc;
    advance     = adv;
    tick();
    redirect = 1'b0;
    advance  = 1'b0;
  endtask

  task automatic checkHead(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, "_pc"}, 64'(opcode_pc), 64'(e.pc));
    checkOutput({tag, "_op"}, 64'(opcode), 64'(e.op));
  endtask

  task automatic consume(input string tag);
    int n;
    n = 0;
    while (!opcode_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, 64'(opcode_valid), 64'd1);
    if (opcode_valid) begin
      checkHead(tag);
      applyStimulus(1'b0, 16'h0, 1'b1);
    end
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    tick();
    while (ibus_fetch && n < 60) begin
      tick();
      n++;
    end
    checkOutput({tag, "_idle"}, 64'(ibus_fetch), 64'd0);
  endtask

  task automatic busAuto(input int lat);
    busOn   = 1;
    busLat  = lat;
    waitCnt = 0;
  endtask

  task automatic busManual();
    busOn     = 0;
    ibus_done = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    advance     = 1'b0;
    ibus_input  = 48'h0;
    ibus_done   = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_fetch", 64'(ibus_fetch), 64'd0);
    checkOutput("rst_valid", 64'(opcode_valid), 64'd0);
    checkOutput("rst_pc", 64'(opcode_pc), 64'd0);
    checkOutput("rst_addr", 64'(ibus_addr), 64'd0);

    // Test 1: fill from address 0 until full
    reset = 1'b0;
    busAuto(0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("t1_log_size", 64'(fetchLog.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("t1_addr%0d", i), 64'(fetchLog[i]), 64'(i));
    checkOutput("t1_full_fetch", 64'(ibus_fetch), 64'd0);
    for (int i = 0; i < 10; i++) pushExp(16'(i));
    consume("t1_pc0");
    checkOutput("t1_left_nopop", 64'(ibus_fetch), 64'd0);

    // Test 2: advance on odd PC pops and restarts fetch at address 4
    consume("t2_pc1");
    checkOutput("t2_refetch", 64'(ibus_fetch), 64'd1);
    checkOutput("t2_addr", 64'(ibus_addr), 64'd4);
    tick();
    checkOutput("t2_refull", 64'(ibus_fetch), 64'd0);
    checkOutput("t2_log", 64'(fetchLog[fetchLog.size()-1]), 64'd4);
    for (int i = 2; i < 10; i++) consume($sformatf("t2_pc%0d", i));

    // Test 3: redirect to 0x0101 while a slow fetch of word 2 is pending
    waitIdle("t3_pre");
    fetchLog.delete();
    sb.delete();
    busAuto(3);
    applyStimulus(1'b1, 16'h0004, 1'b0);
    checkOutput("t3_fetch", 64'(ibus_fetch), 64'd1);
    checkOutput("t3_addr2", 64'(ibus_addr), 64'd2);
    tick();
    applyStimulus(1'b1, 16'h0101, 1'b0);
    checkOutput("t3_drop_fetch", 64'(ibus_fetch), 64'd1);
    checkOutput("t3_drop_addr", 64'(ibus_addr), 64'd2);
    checkOutput("t3_drop_valid", 64'(opcode_valid), 64'd0);
    tick();
    tick();
    checkOutput("t3_new_addr", 64'(ibus_addr), 64'h080);
    checkOutput("t3_discard", 64'(opcode_valid), 64'd0);
    for (int i = 'h101; i < 'h104; i++) pushExp(16'(i));
    for (int i = 0; i < 3; i++) consume($sformatf("t3_op%0d", i));
    checkOutput("t3_log0", 64'(fetchLog[0]), 64'd2);
    checkOutput("t3_log1", 64'(fetchLog[1]), 64'h080);

    // Test 4: push and pop in the same cycle with one word queued
    busAuto(0);
    waitIdle("t4_pre");
    busManual();
    sb.delete();
    pushExp(16'h03FF);
    pushExp(16'h0400);
    applyStimulus(1'b1, 16'h03FF, 1'b0);
    checkOutput("t4_fetch", 64'(ibus_fetch), 64'd1);
    checkOutput("t4_addr", 64'(ibus_addr), 64'h1FF);
    ibus_done  = 1'b1;
    ibus_input = memWord(15'h1FF);
    tick();
    ibus_done = 1'b0;
    checkOutput("t4_valid_a", 64'(opcode_valid), 64'd1);
    checkHead("t4_a");
    ibus_done  = 1'b1;
    ibus_input = memWord(15'h200);
    applyStimulus(1'b0, 16'h0, 1'b1);
    ibus_done = 1'b0;
    checkOutput("t4_valid_b", 64'(opcode_valid), 64'd1);
    checkHead("t4_b");

    // Test 5: address wrap at the top of memory
    busAuto(0);
    waitIdle("t5_pre");
    fetchLog.delete();
    sb.delete();
    pushExp(16'hFFFE);
    pushExp(16'hFFFF);
    pushExp(16'h0000);
    pushExp(16'h0001);
    applyStimulus(1'b1, 16'hFFFE, 1'b0);
    checkOutput("t5_addr", 64'(ibus_addr), 64'h7FFF);
    for (int i = 0; i < 4; i++) consume($sformatf("t5_op%0d", i));
    checkOutput("t5_log0", 64'(fetchLog[0]), 64'h7FFF);
    checkOutput("t5_log1", 64'(fetchLog[1]), 64'h0000);

    // Test 6: reset in the middle of a fetch, late ibus_done ignored
    waitIdle("t6_pre");
    busAuto(3);
    applyStimulus(1'b1, 16'h0040, 1'b0);
    tick();
    checkOutput("t6_pre_fetch", 64'(ibus_fetch), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_fetch", 64'(ibus_fetch), 64'd0);
    checkOutput("t6_rst_valid", 64'(opcode_valid), 64'd0);
    checkOutput("t6_rst_pc", 64'(opcode_pc), 64'd0);
    busManual();
    ibus_done  = 1'b1;
    ibus_input = memWord(15'h020);
    tick();
    reset = 1'b0;
    tick();
    ibus_done = 1'b0;
    checkOutput("t6_no_push", 64'(opcode_valid), 64'd0);
    checkOutput("t6_restart", 64'(ibus_fetch), 64'd1);
    checkOutput("t6_addr0", 64'(ibus_addr), 64'd0);
    fetchLog.delete();
    sb.delete();
    busAuto(0);
    for (int i = 0; i < 4; i++) pushExp(16'(i));
    for (int i = 0; i < 4; i++) consume($sformatf("t6_op%0d", i));
    checkOutput("t6_log0", 64'(fetchLog[0]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
